trig_hit_scheduler: RTL

- Sequences a bank of N_CH latched trigger-input bits (one pulse catcher per channel) and rearms each catcher with a per-channel clear pulse.
- Serialises captured hits to downstream trigger logic or readout over a valid/ready handshake, with round-robin fairness and a programmable readout deadtime.
- Tags each hit with a free-running timestamp and counts hits lost to channel pile-up.

---
 rtl/trig_pkg.sv | 22 ++
 rtl/rr_priority_pick.sv | 33 +++
 rtl/trig_hit_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/trig_pkg.sv
// trig_pkg: shared types for the trigger hit scheduler.
//   state_t   - scheduler FSM states (IDLE, VALID, DEAD).
//   hit_rec_t - the record presented downstream: channel index + timestamp.
// REC_CH_W / REC_TS_W set the record field widths. The scheduler's CH_W /
// TS_W parameters default to them; change both together.
package trig_pkg;

  localparam int REC_CH_W = 4;
  localparam int REC_TS_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    DEAD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [REC_CH_W-1:0] ch;
    logic [REC_TS_W-1:0] ts;
  } hit_rec_t;

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin find-first-set.
//   req   [N]  request vector
//   start [W]  index where the search begins; it wraps from N-1 to 0
//   found      at least one request bit is set
//   idx   [W]  first set bit at or after start (0 when nothing is found)
module rr_priority_pick #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W-1:0] j;

  // Scan from the farthest offset down to offset 0. The last hit written
  // is therefore the closest one to start.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = W'((int'(start) + i) % N);
      if (req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/trig_hit_scheduler.sv
// trig_hit_scheduler: serialises latched trigger hits from N_CH pulse
// catchers onto one valid/ready stream. Each hit carries a timestamp.
//   clk, rst   clock; asynchronous active-high reset
//   hit_in     latched hit levels. Each stays high until its clr pulse.
//   ch_mask    1 = ignore new captures on that channel
//   enable     global capture enable
//   out_ready  downstream accept
//   out_valid  a record is offered (out_ch, out_ts)
//   clr        one-cycle rearm pulse per catcher, registered from the edge
//   busy       FSM not idle, or a hit is still pending
//   drop_cnt   saturating count of hits lost to pile-up
//
// Handshake: a record transfers on a clock edge where out_valid and
// out_ready are both high. While out_valid is high, out_ch and out_ts stay
// stable, and out_valid does not fall until that transfer happens.
// out_valid does not depend on out_ready.
// After each transfer the FSM waits in DEAD for DEAD_CYC clocks before it
// may grant again.
// Debug: the FSM state is held in the enum signal 'state'.
module trig_hit_scheduler
  import trig_pkg::*;
#(
  parameter int N_CH     = 16,
  parameter int CH_W     = REC_CH_W,
  parameter int TS_W     = REC_TS_W,
  parameter int DEAD_CYC = 8,
  parameter int DROP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   hit_in,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic              enable,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [TS_W-1:0]   out_ts,
  output logic [N_CH-1:0]   clr,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int DC_W  = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DC_W-1:0] DEAD_LOAD = DC_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
  // Wide enough for drop_cnt plus every channel dropping in the same cycle.
  localparam int SUM_W = DROP_W + $clog2(N_CH + 1);

  state_t state, state_nxt;

  logic [N_CH-1:0] hit_d;
  logic [N_CH-1:0] pending, pending_nxt;
  logic [N_CH-1:0] edge_v, grant_vec, cap_vec, drop_vec;
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_q [N_CH];
  logic [CH_W-1:0] rr_ptr, pick_idx;
  logic            pick_found, grant, accept;
  logic [DC_W-1:0] dead_cnt;
  hit_rec_t        out_rec;
  logic [SUM_W-1:0]  drop_sum;
  logic [DROP_W-1:0] drop_nxt;

  rr_priority_pick #(.N(N_CH), .W(CH_W)) u_pick (
    .req   (pending),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // ---------------- capture stage ----------------
  always_comb begin
    edge_v    = enable ? (hit_in & ~hit_d & ~ch_mask) : '0;
    grant     = (state == IDLE) && pick_found;
    accept    = (state == VALID) && out_ready;
    grant_vec = grant ? (N_CH'(1) << pick_idx) : '0;
    // A channel that is being granted this cycle counts as free.
    // So a new edge on it becomes a fresh capture, not a drop.
    cap_vec     = edge_v & (~pending | grant_vec);
    drop_vec    = edge_v & pending & ~grant_vec;
    pending_nxt = (pending & ~grant_vec) | cap_vec;
    drop_sum    = SUM_W'(drop_cnt) + SUM_W'($countones(drop_vec));
    drop_nxt    = (drop_sum > SUM_W'({DROP_W{1'b1}})) ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt   <= '0;
      hit_d    <= '0;
      pending  <= '0;
      clr      <= '0;
      drop_cnt <= '0;
      for (int c = 0; c < N_CH; c++) ts_q[c] <= '0;
    end else begin
      ts_cnt   <= ts_cnt + 1'b1;
      hit_d    <= hit_in;
      pending  <= pending_nxt;
      clr      <= edge_v;     // rearm even when the hit was dropped
      drop_cnt <= drop_nxt;
      for (int c = 0; c < N_CH; c++) begin
        if (cap_vec[c]) ts_q[c] <= ts_cnt;
      end
    end
  end

  // ---------------- record, pointer and deadtime ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_rec  <= '0;
      rr_ptr   <= '0;
      dead_cnt <= '0;
    end else begin
      if (grant) begin
        out_rec.ch <= REC_CH_W'(pick_idx);
        out_rec.ts <= REC_TS_W'(ts_q[pick_idx]);
      end
      if (accept) begin
        rr_ptr <= (out_ch == CH_W'(N_CH - 1)) ? '0 : out_ch + 1'b1;
      end
      if (accept) begin
        dead_cnt <= DEAD_LOAD;
      end else if ((state == DEAD) && (dead_cnt != '0)) begin
        dead_cnt <= dead_cnt - 1'b1;
      end
    end
  end

  assign out_ch = CH_W'(out_rec.ch);
  assign out_ts = TS_W'(out_rec.ts);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = VALID;
      VALID:   if (out_ready) state_nxt = (DEAD_CYC == 0) ? IDLE : DEAD;
      DEAD:    if (dead_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == VALID);
    busy      = (state != IDLE) || (|pending);
  end

endmodule
